// File: rtl/dt_pkg.sv
// Shared parameters, FSM encoding and window types for the skeleton extractor.
// SKEL_8CONN_EN selects 8-neighbour comparison (default build: 4 orthogonal neighbours).
package dt_pkg;

    localparam int IMG_W  = 128;
    localparam int DW     = 8;
    localparam int WORD_W = 16;
    localparam int WPR    = IMG_W / WORD_W;
    localparam int RC_W   = $clog2(IMG_W);
    localparam int RA_W   = 2 * RC_W;
    localparam int SA_W   = $clog2(IMG_W * WPR);
    localparam int CNT_W  = 14;
    localparam int BC_W   = $clog2(WORD_W);
    localparam int ZC_W   = $clog2(WPR);
    localparam int K_W    = RC_W + 1;

`ifdef SKEL_8CONN_EN
    localparam logic CONN8 = 1'b1;
`else
    localparam logic CONN8 = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZROW,
        ST_PRIME,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One window column: rows r-1, r, r+1.
    typedef struct packed {
        logic [DW-1:0] t;
        logic [DW-1:0] m;
        logic [DW-1:0] b;
    } col_t;

endpackage

// File: rtl/sk_word_packer.sv
// Serial skeleton bits into 16-bit sti words; first bit lands in the MSB.
// Also emits whole zero words for the border rows, sharing the address counter.
module sk_word_packer
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              zw,
    input  logic              bv,
    input  logic              bit_in,
    output logic              sk_wr,
    output logic [SA_W-1:0]   sk_addr,
    output logic [WORD_W-1:0] sk_do
);

    logic [WORD_W-2:0] sr_q, sr_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [SA_W-1:0]   wa_q, wa_d;
    logic [SA_W-1:0]   addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] do_q, do_d;

    always_comb begin
        sr_d   = sr_q;
        bc_d   = bc_q;
        wa_d   = wa_q;
        wr_d   = 1'b0;
        addr_d = addr_q;
        do_d   = do_q;
        if (clr) begin
            sr_d = '0;
            bc_d = '0;
            wa_d = '0;
        end else if (zw) begin
            wr_d   = 1'b1;
            addr_d = wa_q;
            do_d   = '0;
            wa_d   = wa_q + 1'b1;
        end else if (bv) begin
            sr_d = {sr_q[WORD_W-3:0], bit_in};
            bc_d = bc_q + 1'b1;
            if (bc_q == BC_W'(WORD_W - 1)) begin
                wr_d   = 1'b1;
                addr_d = wa_q;
                do_d   = {sr_q, bit_in};
                wa_d   = wa_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            bc_q   <= '0;
            wa_q   <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            do_q   <= '0;
        end else begin
            sr_q   <= sr_d;
            bc_q   <= bc_d;
            wa_q   <= wa_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            do_q   <= do_d;
        end
    end

    assign sk_wr   = wr_q;
    assign sk_addr = addr_q;
    assign sk_do   = do_q;

endmodule

// File: rtl/dt_skeleton_extract.sv
// Local-maximum skeleton extraction over a 128x128 distance map, 3 reads per column.
// Build option SKEL_8CONN_EN adds the diagonal neighbours to the comparison.
module dt_skeleton_extract
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              res_rd,
    output logic [RA_W-1:0]   res_addr,
    input  logic [DW-1:0]     res_di,
    output logic              sk_wr,
    output logic [SA_W-1:0]   sk_addr,
    output logic [WORD_W-1:0] sk_do,
    output logic [CNT_W-1:0]  sk_cnt,
    output logic              done
);

    state_t            state_q, state_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [1:0]        ph_q, ph_d;
    logic [ZC_W-1:0]   zc_q, zc_d;
    logic              acc;
    logic              last_wr;
    logic [RC_W-1:0]   rrow;

    logic              rd_d, cv_d, z_d;
    logic [RA_W-1:0]   addr_d;
    logic              res_rd_q;
    logic [RA_W-1:0]   res_addr_q;
    logic              t1_cv_q, t1_z_q;
    logic [K_W-1:0]    t1_k_q;
    logic [1:0]        t1_ph_q;
    logic              t2_cv_q, t2_z_q;
    logic [K_W-1:0]    t2_k_q;
    logic [1:0]        t2_ph_q;

    logic [DW-1:0]     top_q, top_d, mid_q, mid_d;
    col_t              a_q, a_d, b_q, b_d, n_col;
    logic              bit_v, bit_s;
    logic              ge_o, ge_d, is_edge;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign acc     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign rrow    = row_q + RC_W'(ph_q) - RC_W'(1);
    assign last_wr = sk_wr && (sk_addr == SA_W'(IMG_W * WPR - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        k_d     = k_q;
        ph_d    = ph_q;
        zc_d    = zc_q;
        rd_d    = 1'b0;
        addr_d  = res_addr_q;
        cv_d    = 1'b0;
        z_d     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (acc) begin
                    state_d = ST_ZROW;
                    row_d   = '0;
                    zc_d    = '0;
                end
            end
            ST_ZROW: begin
                z_d  = 1'b1;
                zc_d = zc_q + 1'b1;
                if (zc_q == ZC_W'(WPR - 1)) begin
                    if (row_q == RC_W'(IMG_W - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_PRIME;
                        row_d   = row_q + 1'b1;
                        k_d     = '0;
                        ph_d    = '0;
                    end
                end
            end
            ST_PRIME, ST_SCAN: begin
                cv_d = 1'b1;
                // Column 128 keeps its three slots but is never read.
                if (k_q < K_W'(IMG_W)) begin
                    rd_d   = 1'b1;
                    addr_d = {rrow, k_q[RC_W-1:0]};
                end
                ph_d = ph_q + 1'b1;
                if (ph_q == 2'd2) begin
                    ph_d = '0;
                    if (k_q == K_W'(IMG_W)) begin
                        k_d   = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == RC_W'(IMG_W - 2)) begin
                            state_d = ST_ZROW;
                            zc_d    = '0;
                        end else begin
                            state_d = ST_PRIME;
                        end
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_wr) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        top_d = top_q;
        mid_d = mid_q;
        a_d   = a_q;
        b_d   = b_q;
        n_col = '0;
        if (t2_cv_q) begin
            unique case (t2_ph_q)
                2'd0:    top_d = res_di;
                2'd1:    mid_d = res_di;
                default: begin
                    if (t2_k_q != K_W'(IMG_W)) begin
                        n_col.t = top_q;
                        n_col.m = mid_q;
                        n_col.b = res_di;
                    end
                    a_d = (t2_k_q == '0) ? '0 : b_q;
                    b_d = n_col;
                end
            endcase
        end
    end

    // Decide pixel k-1 as column k arrives: a=left, b=centre, n_col=right.
    always_comb begin
        ge_o = (b_q.m >= b_q.t) && (b_q.m >= b_q.b) &&
               (b_q.m >= a_q.m) && (b_q.m >= n_col.m);
        ge_d = !CONN8 ||
               ((b_q.m >= a_q.t) && (b_q.m >= a_q.b) &&
                (b_q.m >= n_col.t) && (b_q.m >= n_col.b));
        is_edge = (t2_k_q == K_W'(1)) || (t2_k_q == K_W'(IMG_W));
        bit_v = t2_cv_q && (t2_ph_q == 2'd2) && (t2_k_q != '0);
        bit_s = (b_q.m != '0) && ge_o && ge_d && !is_edge;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (acc) begin
            cnt_d = '0;
        end else if (bit_v && bit_s && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            k_q        <= '0;
            ph_q       <= '0;
            zc_q       <= '0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            t1_cv_q    <= 1'b0;
            t1_z_q     <= 1'b0;
            t1_k_q     <= '0;
            t1_ph_q    <= '0;
            t2_cv_q    <= 1'b0;
            t2_z_q     <= 1'b0;
            t2_k_q     <= '0;
            t2_ph_q    <= '0;
            top_q      <= '0;
            mid_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            k_q        <= k_d;
            ph_q       <= ph_d;
            zc_q       <= zc_d;
            res_rd_q   <= rd_d;
            res_addr_q <= addr_d;
            t1_cv_q    <= cv_d;
            t1_z_q     <= z_d;
            t1_k_q     <= k_q;
            t1_ph_q    <= ph_q;
            t2_cv_q    <= t1_cv_q;
            t2_z_q     <= t1_z_q;
            t2_k_q     <= t1_k_q;
            t2_ph_q    <= t1_ph_q;
            top_q      <= top_d;
            mid_q      <= mid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
        end
    end

    sk_word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc),
        .zw      (t2_z_q),
        .bv      (bit_v),
        .bit_in  (bit_s),
        .sk_wr   (sk_wr),
        .sk_addr (sk_addr),
        .sk_do   (sk_do)
    );

    assign res_rd   = res_rd_q;
    assign res_addr = res_addr_q;
    assign sk_cnt   = cnt_q;
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_dt_skeleton_extract.sv
// Bench for dt_skeleton_extract: random map plus fixed patterns, 2-D reference model.
// Honors SKEL_8CONN_EN the same way as the design build.
module tb_dt_skeleton_extract;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di = 8'd0;
    logic        sk_wr;
    logic [9:0]  sk_addr;
    logic [15:0] sk_do;
    logic [13:0] sk_cnt;
    logic        done;

    dt_skeleton_extract dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .sk_wr    (sk_wr),
        .sk_addr  (sk_addr),
        .sk_do    (sk_do),
        .sk_cnt   (sk_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  img   [0:16383];
    logic [15:0] exp_w [0:1023];
    logic [15:0] cap   [0:1023];
    int          exp_cnt;

    always @(posedge clk) begin
        if (res_rd) res_di <= img[res_addr];
    end

    int  errors = 0;
    int  checks = 0;
    int  wcnt = 0;
    int  done_rises = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int pv(input int r, input int c);
        return int'(img[r*128 + c]);
    endfunction

    task automatic build_model();
        int d;
        bit s;
        exp_cnt = 0;
        for (int i = 0; i < 1024; i++) exp_w[i] = 16'h0000;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                d = pv(r, c);
                s = (d > 0) && d >= pv(r-1, c) && d >= pv(r+1, c) &&
                    d >= pv(r, c-1) && d >= pv(r, c+1);
`ifdef SKEL_8CONN_EN
                s = s && d >= pv(r-1, c-1) && d >= pv(r-1, c+1) &&
                    d >= pv(r+1, c-1) && d >= pv(r+1, c+1);
`endif
                if (s) begin
                    exp_w[r*8 + c/16][15 - (c % 16)] = 1'b1;
                    exp_cnt++;
                end
            end
        end
    endtask

    // Compare process: every write must be the next address with the model's word.
    logic done_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && mon_en) begin
                if (sk_wr) begin
                    checks++;
                    if (wcnt >= 1024 || int'(sk_addr) != wcnt ||
                        sk_do !== exp_w[sk_addr]) begin
                        errors++;
                        $display("FAIL write #%0d: got addr=%0d data=%h want addr=%0d data=%h",
                                 wcnt, sk_addr, sk_do, wcnt % 1024, exp_w[sk_addr]);
                    end
                    cap[sk_addr] = sk_do;
                    wcnt++;
                end
                if (done && !done_prev) done_rises++;
            end
            done_prev = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int v;
    int cyc;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16384; i++) img[i] = 8'd0;
        // Random plateaus/peaks away from the fixed patterns, covering borders.
        for (int r = 0; r < 128; r++) begin
            for (int c = 0; c < 128; c++) begin
                if (r >= 60 || (c >= 64 && r <= 58)) begin
                    v = $urandom_range(0, 9);
                    if (v < 4)       img[r*128+c] = 8'd0;
                    else if (v < 8)  img[r*128+c] = 8'(v - 3);
                    else if (v == 8) img[r*128+c] = 8'd200;
                    else             img[r*128+c] = 8'd255;
                end
            end
        end
        img[5*128+5] = 8'd1;
        for (int r = 9; r <= 11; r++)
            for (int c = 19; c <= 21; c++) img[r*128+c] = 8'd1;
        img[10*128+20] = 8'd2;
        for (int r = 29; r <= 31; r++)
            for (int c = 39; c <= 43; c++) img[r*128+c] = 8'd2;
        for (int c = 40; c <= 42; c++) img[30*128+c] = 8'd3;
        img[50*128+50] = 8'd2;
        img[49*128+49] = 8'd3;
        img[49*128+50] = 8'd1;
        img[51*128+50] = 8'd1;
        img[50*128+49] = 8'd1;
        img[50*128+51] = 8'd1;
        build_model();

        chk("model w40", 32'(exp_w[40]), 32'h0400);
        chk("model w81", 32'(exp_w[81]), 32'h0800);
        chk("model w242", 32'(exp_w[242]), 32'h00E0);
        chk("model w395", 32'(exp_w[395]), 32'h4000);
`ifdef SKEL_8CONN_EN
        chk("model w403", 32'(exp_w[403]), 32'h0000);
`else
        chk("model w403", 32'(exp_w[403]), 32'h2000);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst res_rd", 32'(res_rd), 0);
        chk("rst res_addr", 32'(res_addr), 0);
        chk("rst sk_wr", 32'(sk_wr), 0);
        chk("rst sk_addr/do", {6'd0, sk_addr, sk_do}, 0);
        chk("rst sk_cnt", 32'(sk_cnt), 0);
        chk("rst done", 32'(done), 0);
        reset = 1'b1;

        // Scan aborted by reset at write 300.
        mon_en = 1'b1;
        wcnt = 0;
        pulse_start();
        cyc = 0;
        while (wcnt < 300 && cyc < 40000) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("reach write 300", 32'(wcnt >= 300), 1);
        reset = 1'b0;
        #1;
        chk("abort sk_wr", 32'(sk_wr), 0);
        chk("abort res_rd", 32'(res_rd), 0);
        chk("abort sk_cnt", 32'(sk_cnt), 0);
        chk("abort done", 32'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Full scan with an ignored mid-scan start.
        wcnt = 0;
        done_rises = 0;
        pulse_start();
        cyc = 1;
        while (!done && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 20000);
        end
        start = 1'b0;
        #1;
        chk("done reached", 32'(done), 1);
        chk("scan cycles < 52000", 32'(cyc < 52000), 1);
        chk("write count", 32'(wcnt), 1024);
        chk("sk_cnt", 32'(sk_cnt), 32'(exp_cnt));
        chk("cap w0", 32'(cap[0]), 0);
        chk("cap w40", 32'(cap[40]), 32'h0400);
        chk("cap w81", 32'(cap[81]), 32'h0800);
        chk("cap w242", 32'(cap[242]), 32'h00E0);
        chk("cap w395", 32'(cap[395]), 32'h4000);
`ifdef SKEL_8CONN_EN
        chk("cap w403", 32'(cap[403]), 32'h0000);
`else
        chk("cap w403", 32'(cap[403]), 32'h2000);
`endif
        chk("cap w1023", 32'(cap[1023]), 0);
        repeat (20) @(negedge clk);
        #1;
        chk("done held", 32'(done), 1);
        chk("done rises once", 32'(done_rises), 1);
        chk("no extra writes", 32'(wcnt), 1024);

        // Start while done: new scan, done and count drop.
        wcnt = 0;
        pulse_start();
        #1;
        chk("restart done low", 32'(done), 0);
        chk("restart sk_cnt clr", 32'(sk_cnt), 0);
        repeat (30) @(negedge clk);
        #1;
        chk("restart writes begun", 32'(wcnt >= 8), 1);
        reset = 1'b0;
        mon_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
